// File: rtl/cpu_trace_pkg.sv
// Shared types for the CPU trace capture block: widths, sync nibble,
// framing FSM states and the buffered trace entry layout.
// Optional CPU_TRACE_TIMESTAMP_EN adds an 8-bit timestamp to each entry.
package cpu_trace_pkg;
   localparam int PC_W_DEF = 8;
   localparam int RES_W_DEF = 4;
   localparam int TS_W = 8;
   localparam logic [3:0] SYNC_NIBBLE = 4'hA;

   typedef enum logic [1:0] {
      IDLE,
      SEND_PC,
      SEND_RES
`ifdef CPU_TRACE_TIMESTAMP_EN
      , SEND_TS
`endif
   } trace_state_t;

   typedef struct packed {
      logic [PC_W_DEF-1:0]  pc;
      logic [RES_W_DEF-1:0] res;
`ifdef CPU_TRACE_TIMESTAMP_EN
      logic [TS_W-1:0]      ts;
`endif
   } trace_entry_t;

   localparam int ENTRY_W = $bits(trace_entry_t);
endpackage

// File: rtl/cpu_trace_capture_fifo.sv
// trace_fifo: synchronous FIFO, push/pop/full/empty/level, sync reset.
// Ports: clk, reset, push, pop, wdata, rdata (head), full, empty, level.
module trace_fifo #(
   parameter int W = 12,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_push;
   logic         do_pop;

   // A push into a full FIFO is accepted when the head leaves this cycle.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
               && (wr_ptr[AW] != rd_ptr[AW]);
   assign level = wr_ptr - rd_ptr;
   assign rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end
endmodule

// File: rtl/cpu_trace_capture.sv
// Captures retired-instruction PC/ALU result into a FIFO and streams
// framed bytes (PC, {A,res}[, ts]) over valid/ready. Ports: clk, reset,
// en, pc_in, res_in, out_data/out_valid/out_ready, overflow, level.
// Macro CPU_TRACE_TIMESTAMP_EN adds a cycle-count byte per frame.
module cpu_trace_capture
   import cpu_trace_pkg::*;
#(
   parameter int PC_W = PC_W_DEF,
   parameter int RES_W = RES_W_DEF,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic [PC_W-1:0]        pc_in,
   input  logic [RES_W-1:0]       res_in,
   output logic [7:0]             out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   overflow,
   output logic [$clog2(DEPTH):0] level
);
   trace_state_t    state, state_n;
   trace_entry_t    hold, hold_n, head, wentry;
   logic [PC_W-1:0] last_pc;
   logic            first_flag;
   logic            push, pop, full, empty;
   logic            frame_done;
   logic [7:0]      data_n;
   logic            valid_n;

`ifdef CPU_TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_cnt;

   always_ff @(posedge clk) begin
      if (reset) ts_cnt <= '0;
      else       ts_cnt <= ts_cnt + 8'd1;
   end
`endif

   always_comb begin
      wentry = '0;
      wentry.pc = PC_W_DEF'(pc_in);
      wentry.res = RES_W_DEF'(res_in);
`ifdef CPU_TRACE_TIMESTAMP_EN
      wentry.ts = ts_cnt;
`endif
   end

   // A stalled CPU repeats its PC; log it only once.
   assign push = en && (first_flag || (pc_in != last_pc));

   always_ff @(posedge clk) begin
      if (reset) begin
         last_pc    <= '0;
         first_flag <= 1'b1;
         overflow   <= 1'b0;
      end else begin
         if (en) begin
            last_pc    <= pc_in;
            first_flag <= 1'b0;
         end
         if (push && full && !pop) overflow <= 1'b1;
      end
   end

   trace_fifo #(
      .W(ENTRY_W),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(push),
      .pop(pop),
      .wdata(wentry),
      .rdata(head),
      .full(full),
      .empty(empty),
      .level(level)
   );

   always_comb begin
      state_n    = state;
      hold_n     = hold;
      data_n     = out_data;
      valid_n    = out_valid;
      pop        = 1'b0;
      frame_done = 1'b0;
      unique case (state)
         IDLE: ;
         SEND_PC:
            if (out_ready) begin
               state_n = SEND_RES;
               data_n  = {SYNC_NIBBLE, hold.res};
            end
`ifdef CPU_TRACE_TIMESTAMP_EN
         SEND_RES:
            if (out_ready) begin
               state_n = SEND_TS;
               data_n  = hold.ts;
            end
         SEND_TS:
            frame_done = out_ready;
`else
         SEND_RES:
            frame_done = out_ready;
`endif
         default: state_n = IDLE;
      endcase
      // Load the next frame from IDLE or directly after the last byte.
      if ((state == IDLE) || frame_done) begin
         if (!empty) begin
            pop     = 1'b1;
            hold_n  = head;
            state_n = SEND_PC;
            valid_n = 1'b1;
            data_n  = 8'(head.pc);
         end else if (frame_done) begin
            state_n = IDLE;
            valid_n = 1'b0;
            data_n  = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         hold      <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_n;
         hold      <= hold_n;
         out_data  <= data_n;
         out_valid <= valid_n;
      end
   end
endmodule

// File: tb/tb_cpu_trace_capture.sv
// Scoreboard bench for cpu_trace_capture: directed captures push the
// expected byte stream; a monitor compares every accepted byte.
module tb_cpu_trace_capture;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic [7:0] pc_in = '0;
   logic [3:0] res_in = '0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       overflow;
   logic [4:0] level;

   int         cyc;
   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   cpu_trace_capture #(
      .PC_W(8),
      .RES_W(4),
      .DEPTH(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .en(en),
      .pc_in(pc_in),
      .res_in(res_in),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .overflow(overflow),
      .level(level)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_byte: got %0h expected none", out_data);
         end else begin
            chk("byte", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cap(input logic [7:0] pc, input logic [3:0] res,
                      input bit keep);
      en = 1'b1;
      pc_in = pc;
      res_in = res;
      if (keep) begin
         exp_q.push_back(pc);
         exp_q.push_back({4'hA, res});
`ifdef CPU_TRACE_TIMESTAMP_EN
         exp_q.push_back(cyc[7:0]);
`endif
      end
      step();
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      en = 1'b0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid || level != 0) && t < 300) begin
         step();
         t++;
      end
      chk({name, "_drained"}, {31'h0, t < 300}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      step();
      step();
      chk("rst_valid", {31'h0, out_valid}, 32'd0);
      chk("rst_data", {24'h0, out_data}, 32'd0);
      chk("rst_ovf", {31'h0, overflow}, 32'd0);
      chk("rst_level", {27'h0, level}, 32'd0);
      reset = 1'b0;

      out_ready = 1'b1;
      cap(8'h00, 4'h3, 1'b1);
      chk("t1_level", {27'h0, level}, 32'd1);
      chk("t1_valid_early", {31'h0, out_valid}, 32'd0);
      cap(8'h01, 4'h5, 1'b1);
      chk("t1_valid", {31'h0, out_valid}, 32'd1);
      chk("t1_first", {24'h0, out_data}, 32'h00);
      cap(8'h02, 4'h7, 1'b1);
      drain("t1");
      chk("t1_ovf", {31'h0, overflow}, 32'd0);

      for (int i = 0; i < 5; i++) begin
         cap(8'h10, 4'h6, i == 0);
         chk("t2_level_le1", {31'h0, level <= 5'd1}, 32'd1);
      end
      drain("t2");

      out_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cap(8'h20 + 8'(i), 4'(i), i < 17);
         if (i > 0) begin
            chk("t3_hold_valid", {31'h0, out_valid}, 32'd1);
            chk("t3_hold_data", {24'h0, out_data}, 32'h20);
         end
      end
      chk("t3_level", {27'h0, level}, 32'd16);
      chk("t3_ovf", {31'h0, overflow}, 32'd1);
      drain("t3");

      en = 1'b0;
      reset = 1'b1;
      exp_q.delete();
      step();
      chk("rst2_ovf", {31'h0, overflow}, 32'd0);
      chk("rst2_level", {27'h0, level}, 32'd0);
      reset = 1'b0;

      out_ready = 1'b0;
      for (int i = 0; i < 17; i++) cap(8'h60 + 8'(i), 4'(15 - i), 1'b1);
      chk("t4_full", {27'h0, level}, 32'd16);
      chk("t4_ovf_full", {31'h0, overflow}, 32'd0);
      en = 1'b0;
      out_ready = 1'b1;
      step();
      chk("t4_level_pc", {27'h0, level}, 32'd16);
      cap(8'h71, 4'hF, 1'b1);
      chk("t4_level_swap", {27'h0, level}, 32'd16);
      chk("t4_ovf_swap", {31'h0, overflow}, 32'd0);
      drain("t4");
      chk("t4_ovf_end", {31'h0, overflow}, 32'd0);

      out_ready = 1'b0;
      cap(8'h40, 4'h1, 1'b1);
      en = 1'b0;
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t5_res_valid", {31'h0, out_valid}, 32'd1);
      chk("t5_res_data", {24'h0, out_data}, 32'hA1);
      reset = 1'b1;
      exp_q.delete();
      step();
      chk("t5_rst_valid", {31'h0, out_valid}, 32'd0);
      chk("t5_rst_level", {27'h0, level}, 32'd0);
      reset = 1'b0;
      cap(8'h50, 4'h2, 1'b1);
      drain("t5");

`ifdef CPU_TRACE_TIMESTAMP_EN
      reset = 1'b1;
      exp_q.delete();
      step();
      reset = 1'b0;
      for (int t = 0; t < 10 && cyc != 3; t++) step();
      chk("ts_cyc3", cyc, 32'd3);
      cap(8'h77, 4'h4, 1'b1);
      drain("ts1");
      for (int t = 0; t < 400 && cyc != 300; t++) step();
      chk("ts_cyc300", cyc, 32'd300);
      cap(8'h78, 4'h5, 1'b1);
      drain("ts2");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
